// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: FSM states, writeback source selects, alignment mask.
// Latency and backpressure: none (definitions only).
package mem_stage_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB output register bank: 1-cycle, load captures a bundle, bubble clears valid and pulse flags.
// No backpressure; MEM_TIMEOUT_EN adds the timeout flag.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             bubble,
    input  logic             nxt_valid,
    input  logic             nxt_reg_file_write,
    input  logic [1:0]       nxt_select_mux_4,
    input  logic [WIDTH-1:0] nxt_alu,
    input  logic [WIDTH-1:0] nxt_mem_data,
    input  logic [WIDTH-1:0] nxt_add_pc,
    input  logic             nxt_misalign_err,
    output logic             valid,
    output logic             reg_file_write,
    output logic [1:0]       select_mux_4,
    output logic [WIDTH-1:0] alu,
    output logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] add_pc,
    output logic             misalign_err
`ifdef MEM_TIMEOUT_EN
  , input  logic             nxt_timeout_err,
    output logic             timeout_err
`endif
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid          <= 1'b0;
            reg_file_write <= 1'b0;
            select_mux_4   <= '0;
            alu            <= '0;
            mem_data       <= '0;
            add_pc         <= '0;
            misalign_err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            timeout_err    <= 1'b0;
`endif
        end else if (load) begin
            valid          <= nxt_valid;
            reg_file_write <= nxt_reg_file_write;
            select_mux_4   <= nxt_select_mux_4;
            alu            <= nxt_alu;
            mem_data       <= nxt_mem_data;
            add_pc         <= nxt_add_pc;
            misalign_err   <= nxt_misalign_err;
`ifdef MEM_TIMEOUT_EN
            timeout_err    <= nxt_timeout_err;
`endif
        end else if (bubble) begin
            // Data fields hold; only the qualifiers and one-cycle pulses drop.
            valid          <= 1'b0;
            reg_file_write <= 1'b0;
            misalign_err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            timeout_err    <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word loads/stores over req/ack; non-memory ops 1 cycle, memory ops >= 2 cycles, stall_out holds EX.
// MEM_TIMEOUT_EN adds a WAIT-cycle abort with timeout_err_out.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             mem_re_in,
    input  logic             mem_we_in,
    input  logic             reg_file_write_in,
    input  logic [1:0]       select_mux_4_in,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] reg_b_in,
    input  logic [WIDTH-1:0] add_pc_in,
    output logic             stall_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             valid_out,
    output logic             reg_file_write_out,
    output logic [1:0]       select_mux_4_out,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] mem_data_out,
    output logic [WIDTH-1:0] add_pc_out,
    output logic             misalign_err_out
`ifdef MEM_TIMEOUT_EN
  , output logic             timeout_err_out
`endif
);

    logic [0:0] state;
    logic       mem_op;
    logic       aligned;
    logic       is_load;
    logic       ack_hit;
    logic       timeout_hit;
    logic       finish;
    logic       misalign;
    logic       wb_load;

    assign mem_op  = valid_in & (mem_re_in | mem_we_in);
    assign aligned = is_word_aligned(alu_in[1:0]);
    assign is_load = mem_re_in & ~mem_we_in;
    assign ack_hit = (state == ST_WAIT) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;
    logic [CNT_W-1:0] wait_cnt;

    // An ack in the final cycle wins over the abort.
    assign timeout_hit = (state == ST_WAIT) & ~dmem_ack
                       & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wait_cnt <= '0;
        end else if (!dmem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign finish    = ack_hit | timeout_hit;
    assign misalign  = (state == ST_IDLE) & mem_op & ~aligned;
    assign stall_out = mem_op & aligned & ~finish;

    // EX holds its bundle during WAIT, so the address/data path stays stable without a copy.
    assign dmem_we    = mem_we_in;
    assign dmem_addr  = alu_in;
    assign dmem_wdata = reg_b_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (mem_op && aligned) begin
                state    <= ST_WAIT;
                dmem_req <= 1'b1;
            end
        end else if (finish) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
        end
    end

    assign wb_load = ((state == ST_IDLE) & ~(mem_op & aligned)) | finish;

    mem_wb_reg #(.WIDTH(WIDTH)) u_mem_wb_reg (
        .clk                (clk),
        .reset              (reset),
        .load               (wb_load),
        .bubble             (~wb_load),
        .nxt_valid          ((state == ST_WAIT) | valid_in),
        .nxt_reg_file_write (valid_in & reg_file_write_in & ~misalign & ~timeout_hit),
        .nxt_select_mux_4   (select_mux_4_in),
        .nxt_alu            (alu_in),
        .nxt_mem_data       ((ack_hit & is_load) ? dmem_rdata : '0),
        .nxt_add_pc         (add_pc_in),
        .nxt_misalign_err   (misalign),
        .valid              (valid_out),
        .reg_file_write     (reg_file_write_out),
        .select_mux_4       (select_mux_4_out),
        .alu                (alu_out),
        .mem_data           (mem_data_out),
        .add_pc             (add_pc_out),
        .misalign_err       (misalign_err_out)
`ifdef MEM_TIMEOUT_EN
      , .nxt_timeout_err    (timeout_hit),
        .timeout_err        (timeout_err_out)
`endif
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, directed multi-cycle sequences, randomized ops against a memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in, mem_re_in, mem_we_in, reg_file_write_in;
    logic [1:0]   select_mux_4_in;
    logic [W-1:0] alu_in, reg_b_in, add_pc_in;
    logic         stall_out, dmem_req, dmem_we, dmem_ack;
    logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic         valid_out, reg_file_write_out, misalign_err_out;
    logic [1:0]   select_mux_4_out;
    logic [W-1:0] alu_out, mem_data_out, add_pc_out;
`ifdef MEM_TIMEOUT_EN
    logic         timeout_err_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .WIDTH(W)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .valid_in           (valid_in),
        .mem_re_in          (mem_re_in),
        .mem_we_in          (mem_we_in),
        .reg_file_write_in  (reg_file_write_in),
        .select_mux_4_in    (select_mux_4_in),
        .alu_in             (alu_in),
        .reg_b_in           (reg_b_in),
        .add_pc_in          (add_pc_in),
        .stall_out          (stall_out),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .valid_out          (valid_out),
        .reg_file_write_out (reg_file_write_out),
        .select_mux_4_out   (select_mux_4_out),
        .alu_out            (alu_out),
        .mem_data_out       (mem_data_out),
        .add_pc_out         (add_pc_out),
        .misalign_err_out   (misalign_err_out)
`ifdef MEM_TIMEOUT_EN
      , .timeout_err_out    (timeout_err_out)
`endif
    );

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic re, input logic we, input logic rfw,
                         input logic [1:0] sel, input logic [W-1:0] alu,
                         input logic [W-1:0] b, input logic [W-1:0] pc);
        valid_in          = v;
        mem_re_in         = re;
        mem_we_in         = we;
        reg_file_write_in = rfw;
        select_mux_4_in   = sel;
        alu_in            = alu;
        reg_b_in          = b;
        add_pc_in         = pc;
    endtask

    // Leaves the bench at posedge+1, where outputs of the edge are settled and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         v, re, we, rfw;
        logic [1:0]   sel;
        logic [W-1:0] alu, pc;
        logic         e_valid, e_rfw, e_mis;
    } vec_t;

    vec_t tbl[8];

    logic [W-1:0] mem_model [logic [W-1:0]];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, WB_ALU, 32'h3,        32'h40, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, WB_ALU, 32'h55,       32'h44, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, WB_PC,  32'hFFFFFFFF, 32'h48, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, WB_MEM, 32'h102,      32'h4C, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, WB_ALU, 32'h3,        32'h50, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, WB_MEM, 32'h100,      32'h54, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, WB_MEM, 32'h201,      32'h58, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, WB_MEM, 32'h7,        32'h5C, 1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #2;
        chk1("rst.valid_out", valid_out, 1'b0);
        chk1("rst.dmem_req", dmem_req, 1'b0);
        chk1("rst.rfw_out", reg_file_write_out, 1'b0);
        chkw("rst.mem_data", mem_data_out, '0);
        chkw("rst.alu_out", alu_out, '0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Single-cycle behaviours: pass-through and misalignment.
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].re, tbl[i].we, tbl[i].rfw, tbl[i].sel, tbl[i].alu,
                  32'hCAFE0000 + W'(i), tbl[i].pc);
            @(negedge clk);
            chk1("tbl.stall", stall_out, 1'b0);
            chk1("tbl.req", dmem_req, 1'b0);
            tick();
            chk1("tbl.valid_out", valid_out, tbl[i].e_valid);
            chk1("tbl.rfw_out", reg_file_write_out, tbl[i].e_rfw);
            chk1("tbl.misalign", misalign_err_out, tbl[i].e_mis);
            chkw("tbl.alu_out", alu_out, tbl[i].alu);
            chkw("tbl.add_pc", add_pc_out, tbl[i].pc);
            chkw("tbl.sel", W'(select_mux_4_out), W'(tbl[i].sel));
            chkw("tbl.mem_data", mem_data_out, '0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        tick();

        // Load acked after three wait cycles: four stall cycles in total.
        drive(1'b1, 1'b1, 1'b0, 1'b1, WB_MEM, 32'h100, 32'h0, 32'h80);
        @(negedge clk);
        chk1("ld.stall_idle", stall_out, 1'b1);
        chk1("ld.req_idle", dmem_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk1("ld.req", dmem_req, 1'b1);
            chkw("ld.addr", dmem_addr, 32'h100);
            chk1("ld.we", dmem_we, 1'b0);
            chk1("ld.stall", stall_out, 1'b1);
            chk1("ld.bubble", valid_out, 1'b0);
        end
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk1("ld.stall_ack", stall_out, 1'b0);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        chk1("ld.valid_out", valid_out, 1'b1);
        chkw("ld.mem_data", mem_data_out, 32'hDEADBEEF);
        chk1("ld.rfw_out", reg_file_write_out, 1'b1);
        chk1("ld.req_done", dmem_req, 1'b0);
        tick();
        chk1("ld.pulse_end", valid_out, 1'b0);

        // Store acked in its first wait cycle.
        drive(1'b1, 1'b0, 1'b1, 1'b0, WB_ALU, 32'h204, 32'h12345678, 32'h84);
        @(negedge clk);
        chk1("st.stall_idle", stall_out, 1'b1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        @(negedge clk);
        chk1("st.req", dmem_req, 1'b1);
        chk1("st.we", dmem_we, 1'b1);
        chkw("st.wdata", dmem_wdata, 32'h12345678);
        chkw("st.addr", dmem_addr, 32'h204);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        chk1("st.valid_out", valid_out, 1'b1);
        chkw("st.mem_data", mem_data_out, '0);

        // Asynchronous reset in WAIT, then stray acks in IDLE.
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, WB_MEM, 32'h300, 32'h0, 32'h88);
        tick();
        @(negedge clk);
        chk1("arst.req_before", dmem_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk1("arst.req", dmem_req, 1'b0);
        chk1("arst.valid_out", valid_out, 1'b0);
        chk1("arst.stall_idle", stall_out, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0BAD0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1("spur.valid_out", valid_out, 1'b0);
            chk1("spur.req", dmem_req, 1'b0);
            chkw("spur.mem_data", mem_data_out, '0);
        end
        dmem_ack = 1'b0;

        // Randomized ops; the memory model returns the last value stored at an address.
        for (int n = 0; n < 150; n++) begin
            logic         v, re, we, rfw, is_mem, ok_align, e_mis;
            logic [1:0]   sel;
            logic [W-1:0] alu, b, pc, rd, e_data;
            int           dly;
            v   = ($urandom_range(0, 7) != 0);
            re  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            rfw = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 2));
            alu = W'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 3) == 0) alu = alu + W'($urandom_range(1, 3));
            b   = $urandom;
            pc  = $urandom;
            is_mem   = v && (re || we);
            ok_align = (alu % 4) == 0;
            e_mis    = is_mem && !ok_align;
            e_data   = '0;
            drive(v, re, we, rfw, sel, alu, b, pc);
            dmem_ack = 1'b0;
            @(negedge clk);
            chk1("rnd.stall", stall_out, is_mem && ok_align);
            if (is_mem && ok_align) begin
                dly = $urandom_range(0, 3);
                tick();
                for (int w = 0; w < dly; w++) begin
                    @(negedge clk);
                    chk1("rnd.req_wait", dmem_req, 1'b1);
                    chk1("rnd.bubble", valid_out, 1'b0);
                    tick();
                end
                if (we) rd = $urandom;
                else rd = mem_model.exists(alu) ? mem_model[alu] : ~alu;
                dmem_rdata = rd;
                dmem_ack   = 1'b1;
                @(negedge clk);
                chk1("rnd.req", dmem_req, 1'b1);
                chkw("rnd.addr", dmem_addr, alu);
                chk1("rnd.we", dmem_we, we);
                chk1("rnd.stall_ack", stall_out, 1'b0);
                if (we) begin
                    chkw("rnd.wdata", dmem_wdata, b);
                    mem_model[alu] = b;
                end else begin
                    e_data = rd;
                end
            end else begin
                chk1("rnd.no_req", dmem_req, 1'b0);
            end
            tick();
            dmem_ack = 1'b0;
            chk1("rnd.valid_out", valid_out, is_mem ? 1'b1 : v);
            chk1("rnd.rfw_out", reg_file_write_out, v && rfw && !e_mis);
            chk1("rnd.misalign", misalign_err_out, e_mis);
            chkw("rnd.alu_out", alu_out, alu);
            chkw("rnd.add_pc", add_pc_out, pc);
            chkw("rnd.sel", W'(select_mux_4_out), W'(sel));
            chkw("rnd.mem_data", mem_data_out, e_data);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        end

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after four wait cycles.
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, WB_MEM, 32'h400, 32'h0, 32'h90);
        dmem_ack = 1'b0;
        @(negedge clk);
        chk1("to.stall_idle", stall_out, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk1("to.req", dmem_req, 1'b1);
            chk1("to.stall", stall_out, 1'b1);
            chk1("to.err_early", timeout_err_out, 1'b0);
        end
        tick();
        @(negedge clk);
        chk1("to.stall_release", stall_out, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        chk1("to.err", timeout_err_out, 1'b1);
        chk1("to.req_drop", dmem_req, 1'b0);
        chk1("to.valid_out", valid_out, 1'b1);
        chk1("to.rfw_out", reg_file_write_out, 1'b0);
        chkw("to.mem_data", mem_data_out, '0);
        tick();
        chk1("to.err_pulse", timeout_err_out, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the registered EX outputs (ALU result, store data, memory enables, writeback controls) and performs word loads/stores on a req/ack data-memory port.
- Produces the registered MEM/WB bundle for writeback.
- Stalls EX while a memory transaction is outstanding. Non-memory instructions pass through with one-cycle latency.

Parameters:
- WIDTH, 32, datapath/address width.
- TIMEOUT_CYCLES, 16, max WAIT cycles before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-low reset (0 = reset asserted)
- valid_in  in  1  EX bundle holds a real instruction
- mem_re_in  in  1  load
- mem_we_in  in  1  store
- reg_file_write_in  in  1  writeback enable
- select_mux_4_in  in  2  writeback source select, forwarded
- alu_in  in  WIDTH  ALU result / memory address
- reg_b_in  in  WIDTH  store data
- add_pc_in  in  WIDTH  PC+offset, forwarded
- stall_out  out  1  EX must hold its outputs at next edge
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  WIDTH  word address (byte-addressed, [1:0]=0)
- dmem_wdata  out  WIDTH  write data
- dmem_ack  in  1  request completed this cycle
- dmem_rdata  in  WIDTH  read data, valid with dmem_ack
- valid_out  out  1  MEM/WB bundle valid
- reg_file_write_out  out  1
- select_mux_4_out  out  2
- alu_out  out  WIDTH
- mem_data_out  out  WIDTH  load result
- add_pc_out  out  WIDTH
- misalign_err_out  out  1  one-cycle pulse with valid_out

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - dmem_req=0; all MEM/WB outputs 0.
  - stall_out follows its combinational equation with state IDLE.
  - Reset mid-transaction drops dmem_req immediately and abandons the access.
- States: IDLE, WAIT.
- Memory op: valid_in & (mem_re_in | mem_we_in).
  - If both enables are set, the op is a store; the load is ignored and mem_data_out=0.
- IDLE, no memory op:
  - Next edge: valid_out=valid_in.
  - alu_out, add_pc_out, select_mux_4_out copied.
  - reg_file_write_out = reg_file_write_in & valid_in; mem_data_out=0.
- IDLE, memory op, alu_in[1:0]!=0 (misaligned):
  - No request.
  - Next edge: valid_out=1, misalign_err_out=1, reg_file_write_out=0.
- IDLE, aligned memory op:
  - Next state WAIT; valid_out=0 (bubble).
  - dmem_req=1 registered, with dmem_we, dmem_addr=alu_in, dmem_wdata=reg_b_in.
- WAIT:
  - dmem_req held high; addr/we/wdata driven from inputs (held stable by the stall).
  - valid_out=0 each cycle without ack.
  - On dmem_ack: next edge dmem_req=0, state IDLE, valid_out=1, fields copied, mem_data_out = load ? dmem_rdata : 0.
- stall_out = valid_in & (mem_re_in|mem_we_in) & aligned & !(state==WAIT & dmem_ack). Combinational.
- Latency: non-memory op 1 cycle; memory op minimum 2 cycles (ack on first WAIT cycle); +1 per wait cycle.
- dmem_ack in IDLE is spurious and ignored.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after the first completes, so every op has a 1-cycle idle gap before its request.
- All arithmetic is unsigned and full width; no wrap concerns except the timeout counter.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 5-bit-minimum counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: next edge dmem_req=0, IDLE, valid_out=1, reg_file_write_out=0, mem_data_out=0, timeout_err_out=1 (extra 1-bit output port, one-cycle pulse).
  - An ack arriving in the same cycle as the timeout wins; no error.
- Undefined: no counter, no timeout_err_out port; WAIT persists indefinitely.

Decomposition:
- Shared package:
  - state encoding (ST_IDLE, ST_WAIT)
  - select_mux_4 encodings (WB_ALU, WB_MEM, WB_PC)
  - WORD_ALIGN_MASK=2'b11
  - default WIDTH
- Sub-module mem_wb_reg: the async-reset MEM/WB output register bank with load enable and bubble (valid clear). The FSM/handshake stays in mem_stage.

Test Plan:
- Non-memory op: alu_in=0x3, reg_file_write_in=1 -> next cycle valid_out=1, alu_out=0x3, reg_file_write_out=1, stall_out never 1.
- Load, ack after 3 WAIT cycles, dmem_rdata=0xDEADBEEF, alu_in=0x100 -> dmem_addr=0x100, stall_out=1 for 4 cycles, then valid_out=1, mem_data_out=0xDEADBEEF.
- Store alu_in=0x204, reg_b_in=0x12345678, immediate ack -> dmem_we=1, dmem_wdata=0x12345678, 2-cycle latency, mem_data_out=0.
- Misaligned load alu_in=0x102 -> no dmem_req, next cycle misalign_err_out=1, reg_file_write_out=0.
- reset=0 asserted during WAIT -> dmem_req=0 and valid_out=0 without waiting for clk; spurious dmem_ack in IDLE afterwards produces no output.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 WAIT cycles timeout_err_out=1, dmem_req drops, stall_out releases.
